mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/twitchcore_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 52 +++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/twitchcore_pkg.sv
// Shared definitions for the twitchcore memory path: access-size codes,
// default RAM depth, response-FSM state and port tags, write-strobe helper.
package twitchcore_pkg;

   localparam int MEM_AW_DEFAULT = 14;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } resp_state_e;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] strb;
      case (size)
         SZ_B:    strb = 4'b0001 << off;
         SZ_H:    strb = 4'b0011 << off;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, pointer remembers
// the last port granted so a tie goes to the other one.
module rr_arb2
   import twitchcore_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic i_req_i,
   input  logic d_req_i,
   output logic i_gnt_o,
   output logic d_gnt_o
);

   port_e last_q;
   port_e last_d;

   always_comb begin
      i_gnt_o = 1'b0;
      d_gnt_o = 1'b0;
      // resetn is active-high: requests are ignored while it is asserted
      if (!resetn) begin
         if (i_req_i && d_req_i) begin
            if (last_q == PORT_D) begin
               i_gnt_o = 1'b1;
            end else begin
               d_gnt_o = 1'b1;
            end
         end else begin
            i_gnt_o = i_req_i;
            d_gnt_o = d_req_i;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (i_gnt_o) begin
         last_d = PORT_I;
      end else if (d_gnt_o) begin
         last_d = PORT_D;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         last_q <= PORT_D;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the fetch and data ports: arbitration,
// legality checking, byte-lane steering and a one-cycle response path.
module mem_arbiter
   import twitchcore_pkg::*;
#(
   parameter int MEM_AW = MEM_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [1:0]        d_size,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [31:0]       mem_rdata
);

   rr_arb2 u_arb (
      .clk     (clk),
      .resetn  (resetn),
      .i_req_i (i_req),
      .d_req_i (d_req),
      .i_gnt_o (i_gnt),
      .d_gnt_o (d_gnt)
   );

   logic        i_legal;
   logic        d_aligned;
   logic        d_legal;
   logic        gnt_any;
   logic        acc_legal;
   logic        acc_we;
   logic [31:0] acc_addr;

   assign i_legal = (i_addr[1:0] == 2'b00) && ((i_addr >> (MEM_AW + 2)) == 32'd0);

   always_comb begin
      case (d_size)
         SZ_B:    d_aligned = 1'b1;
         SZ_H:    d_aligned = !d_addr[0];
         SZ_W:    d_aligned = (d_addr[1:0] == 2'b00);
         default: d_aligned = 1'b0;
      endcase
   end

   assign d_legal   = d_aligned && ((d_addr >> (MEM_AW + 2)) == 32'd0);
   assign gnt_any   = i_gnt || d_gnt;
   assign acc_addr  = d_gnt ? d_addr : i_addr;
   assign acc_legal = d_gnt ? d_legal : i_legal;
   assign acc_we    = d_gnt && d_we;

   assign mem_en    = gnt_any && acc_legal;
   assign mem_we    = mem_en && acc_we;
   assign mem_addr  = acc_addr[MEM_AW+1:2];
   assign mem_wstrb = mem_we ? wstrb_f(d_size, d_addr[1:0]) : 4'b0000;

   // Sub-word writes replicate the payload so the strobe alone selects lanes
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign mem_wdata[8*gi +: 8] = (d_size == SZ_B) ? d_wdata[7:0]
                                     : (d_size == SZ_H) ? d_wdata[8*(gi%2) +: 8]
                                     :                    d_wdata[8*gi +: 8];
      end
   endgenerate

   resp_state_e state_q, state_d;
   port_e       tag_q, tag_d;
   logic        err_q, err_d;
   logic        wr_q, wr_d;

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q <= ST_IDLE;
         tag_q   <= PORT_I;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      err_d   = err_q;
      wr_d    = wr_q;
      case (state_q)
         ST_IDLE: if (gnt_any) state_d = ST_RESP;
         ST_RESP: state_d = gnt_any ? ST_RESP : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (gnt_any) begin
         tag_d = d_gnt ? PORT_D : PORT_I;
         err_d = !acc_legal;
         wr_d  = acc_we;
      end
   end

   logic [31:0] resp_data;
   assign resp_data = (err_q || wr_q) ? 32'd0 : mem_rdata;

   always_comb begin
      i_rvalid = 1'b0;
      i_err    = 1'b0;
      i_rdata  = 32'd0;
      d_rvalid = 1'b0;
      d_err    = 1'b0;
      d_rdata  = 32'd0;
      // A reset in the response cycle swallows the pending response
      if (state_q == ST_RESP && !resetn) begin
         if (tag_q == PORT_I) begin
            i_rvalid = 1'b1;
            i_err    = err_q;
            i_rdata  = resp_data;
         end else begin
            d_rvalid = 1'b1;
            d_err    = err_q;
            d_rdata  = resp_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and a response
// scoreboard; each cycle checks grants, RAM drive and the pending response.
module tb_mem_arbiter;
   import twitchcore_pkg::*;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          resetn;
   logic          i_req;
   logic [31:0]   i_addr;
   logic          i_gnt, i_rvalid, i_err;
   logic [31:0]   i_rdata;
   logic          d_req, d_we;
   logic [31:0]   d_addr, d_wdata;
   logic [1:0]    d_size;
   logic          d_gnt, d_rvalid, d_err;
   logic [31:0]   d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_AW(AW)) dut (
      .clk(clk), .resetn(resetn),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
   );

   // Behavioural single-port RAM, filled with an address-derived pattern
   logic [31:0] ram [0:(1<<AW)-1];
   logic        ram_init_done = 1'b0;
   logic [31:0] merged;

   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int k = 0; k < (1 << AW); k++) begin
            ram[k] <= {16'hC0DE ^ k[15:0], k[15:0]};
         end
         ram_init_done <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) begin
            merged = ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
               if (mem_wstrb[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            ram[mem_addr] <= merged;
         end else begin
            mem_rdata <= ram[mem_addr];
         end
      end
   end

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic last_d_m = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic ireq, input logic [31:0] ia,
                      input logic dreq, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [1:0] ds);
      logic        eg_i, eg_d, legal, we, en, has;
      logic [31:0] a, wd, rd_i, rd_d;
      logic [3:0]  st;
      exp_t        e, p;
      resetn = rst;  i_req = ireq; i_addr = ia;
      d_req = dreq;  d_we = dwe;   d_addr = da; d_wdata = dwd; d_size = ds;
      #1;
      eg_i = 1'b0;
      eg_d = 1'b0;
      if (!rst) begin
         if (ireq && dreq) begin
            if (last_d_m) eg_i = 1'b1; else eg_d = 1'b1;
         end else begin
            eg_i = ireq;
            eg_d = dreq;
         end
      end
      chk("i_gnt", i_gnt, eg_i);
      chk("d_gnt", d_gnt, eg_d);

      if (eg_d) begin
         a = da;
         legal = (ds != 2'd3) && !(ds == 2'd1 && da[0]) && !(ds == 2'd2 && da[1:0] != 2'b00)
                 && (da[31:AW+2] == '0);
      end else begin
         a = ia;
         legal = (ia[1:0] == 2'b00) && (ia[31:AW+2] == '0);
      end
      we = eg_d && dwe;
      en = (eg_i || eg_d) && legal;
      st = 4'b0000;
      wd = dwd;
      if (en && we) begin
         case (ds)
            2'd0: begin st = 4'b0001 << da[1:0]; wd = {4{dwd[7:0]}}; end
            2'd1: begin st = 4'b0011 << da[1:0]; wd = {2{dwd[15:0]}}; end
            default: st = 4'b1111;
         endcase
      end
      chk("mem_en", mem_en, en);
      chk("mem_we", mem_we, en && we);
      chk("mem_wstrb", mem_wstrb, st);
      if (en) chk("mem_addr", mem_addr, a[AW+1:2]);
      if (en && we) chk("mem_wdata", mem_wdata, wd);

      has = 1'b0;
      p = '{port: 1'b0, err: 1'b0, rdata: 32'd0};
      if (sb.size() > 0) begin
         p = sb.pop_front();
         has = !rst;
      end
      chk("i_rvalid", i_rvalid, has && !p.port);
      chk("d_rvalid", d_rvalid, has && p.port);
      chk("i_err", i_err, has && !p.port && p.err);
      chk("d_err", d_err, has && p.port && p.err);
      rd_i = (has && !p.port) ? p.rdata : 32'd0;
      rd_d = (has && p.port) ? p.rdata : 32'd0;
      chk("i_rdata", i_rdata, rd_i);
      chk("d_rdata", d_rdata, rd_d);

      if (eg_i || eg_d) begin
         e.port  = eg_d;
         e.err   = !legal;
         e.rdata = (!legal || we) ? 32'd0 : ram[a[AW+1:2]];
         sb.push_back(e);
      end
      $display("t=%0t rst=%0b ireq=%0b ia=%h dreq=%0b we=%0b da=%h sz=%0d -> ignt=%0b dgnt=%0b en=%0b ivld=%0b dvld=%0b",
               $time, rst, ireq, ia, dreq, dwe, da, ds, i_gnt, d_gnt, mem_en, i_rvalid, d_rvalid);

      if (rst) last_d_m = 1'b1;
      else if (eg_i) last_d_m = 1'b0;
      else if (eg_d) last_d_m = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      resetn = 1'b1; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0;  d_we = 1'b0;  d_addr = '0; d_wdata = '0; d_size = SZ_W;
      @(negedge clk);
      // Reset with requests pending: nothing granted
      cyc(1, 1, 32'h100, 1, 0, 32'h200, 0, SZ_W);
      cyc(1, 1, 32'h100, 1, 0, 32'h200, 0, SZ_W);
      // Continuous tie: fetch first, then alternating
      for (int n = 0; n < 6; n++) cyc(0, 1, 32'h200, 1, 0, 32'h200, 0, SZ_W);
      // Lone fetch at 0x100
      cyc(0, 1, 32'h100, 0, 0, 32'h0, 0, SZ_W);
      // Byte write, read-back, half write, word write
      cyc(0, 0, 32'h0, 1, 1, 32'h203, 32'h0000_00AB, SZ_B);
      cyc(0, 0, 32'h0, 1, 0, 32'h200, 0, SZ_W);
      cyc(0, 0, 32'h0, 1, 1, 32'h202, 32'h5555_1234, SZ_H);
      cyc(0, 0, 32'h0, 1, 1, 32'h204, 32'hDEAD_BEEF, SZ_W);
      cyc(0, 1, 32'h204, 1, 0, 32'h200, 0, SZ_W);
      cyc(0, 1, 32'h204, 1, 0, 32'h200, 0, SZ_W);
      cyc(0, 0, 32'h0, 1, 0, 32'h203, 0, SZ_B);
      // Illegal accesses
      cyc(0, 0, 32'h0, 1, 1, 32'h201, 32'hFFFF, SZ_H);
      cyc(0, 1, 32'h0001_0000, 0, 0, 32'h0, 0, SZ_W);
      cyc(0, 1, 32'h102, 0, 0, 32'h0, 0, SZ_W);
      cyc(0, 0, 32'h0, 1, 0, 32'h200, 0, 2'd3);
      cyc(0, 0, 32'h0, 1, 0, 32'h0001_0003, 0, SZ_B);
      cyc(0, 0, 32'h0, 1, 0, 32'h202, 0, SZ_W);
      cyc(0, 1, 32'h3FFFC, 1, 0, 32'hFFFC, 0, SZ_W);
      cyc(0, 1, 32'h3FFFC, 1, 0, 32'hFFFC, 0, SZ_W);
      // Reset in the cycle after a data grant, then tie goes to fetch
      cyc(0, 0, 32'h0, 1, 0, 32'h208, 0, SZ_W);
      cyc(1, 1, 32'h100, 1, 0, 32'h200, 0, SZ_W);
      cyc(0, 1, 32'h10C, 0, 0, 32'h0, 0, SZ_W);
      cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, SZ_W);
      cyc(0, 1, 32'h100, 1, 0, 32'h200, 0, SZ_W);
      cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, SZ_W);
      cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, SZ_W);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
